// File: rtl/puf_seq_pkg.sv
// Shared definitions for the PUF challenge-response sequencer:
// state encoding, challenge LFSR and the zero-seed substitute.
package puf_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RELAX,
        ST_ARM,
        ST_SAMPLE,
        ST_NEXTBIT,
        ST_DONE
    } state_t;

    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

    // Taps 7,5,4,3 fold into the new LSB; an all-zero state would lock up.
    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], ^(x & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer bringing the asynchronous PUF output into clk.
module puf_resp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/puf_crp_sequencer.sv
// Drives challenges and excitation edges into the XOR arbiter PUF, majority-votes
// its output per challenge and returns the packed response over valid/ready.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start
// RELAX    | PUF_In low for SETTLE_CYCLES
// ARM      | PUF_In high for SETTLE_CYCLES
// SAMPLE   | one cycle, accumulate synchronized PUF output as a vote
// NEXTBIT  | one cycle, store voted bit, advance challenge LFSR
// DONE     | resp_word valid, waiting for resp_ready
module puf_crp_sequencer
    import puf_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int VOTES         = 5,
    parameter int RESP_BITS     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           seed,
    output logic [7:0]           CH,
    output logic                 PUF_In,
    input  logic                 XOR_PUF_Out,
    output logic [RESP_BITS-1:0] resp_word,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 busy
);

    localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int VW = $clog2(VOTES + 1);
    localparam int BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [VW-1:0] LAST_VOTE   = VW'(VOTES - 1);
    localparam logic [VW-1:0] HALF_VOTES  = VW'(VOTES / 2);
    localparam logic [BW-1:0] LAST_BIT    = BW'(RESP_BITS - 1);

    state_t          state, state_next;
    logic [TW-1:0]   tmr;
    logic [VW-1:0]   vote_cnt;
    logic [VW-1:0]   ones_cnt;
    logic [BW-1:0]   bit_cnt;
    logic            puf_sync;
    logic            tmr_zero;
    logic            tmr_load;

    puf_resp_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (XOR_PUF_Out),
        .q   (puf_sync)
    );

    assign tmr_zero = (tmr == '0);

    always_comb begin
        state_next = state;
        PUF_In     = 1'b0;
        resp_valid = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE:    if (start) state_next = ST_RELAX;
            ST_RELAX:   if (tmr_zero) state_next = ST_ARM;
            ST_ARM: begin
                PUF_In = 1'b1;
                if (tmr_zero) state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                PUF_In     = 1'b1;
                state_next = (vote_cnt == LAST_VOTE) ? ST_NEXTBIT : ST_RELAX;
            end
            ST_NEXTBIT: state_next = (bit_cnt == LAST_BIT) ? ST_DONE : ST_RELAX;
            ST_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = ST_IDLE;
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    // Timer reloads on every entry into a settle phase and counts down to zero.
    assign tmr_load = (state_next != state) &&
                      ((state_next == ST_RELAX) || (state_next == ST_ARM));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            vote_cnt  <= '0;
            ones_cnt  <= '0;
            bit_cnt   <= '0;
            CH        <= '0;
            resp_word <= '0;
        end else begin
            state <= state_next;

            if (tmr_load)
                tmr <= SETTLE_LOAD;
            else if (!tmr_zero)
                tmr <= tmr - TW'(1);

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        CH       <= (seed == 8'h00) ? ZERO_SEED_SUB : seed;
                        vote_cnt <= '0;
                        ones_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                ST_SAMPLE: begin
                    ones_cnt <= ones_cnt + VW'(puf_sync);
                    vote_cnt <= vote_cnt + VW'(1);
                end
                ST_NEXTBIT: begin
                    resp_word[bit_cnt] <= (ones_cnt > HALF_VOTES);
                    CH                 <= lfsr_next(CH);
                    ones_cnt           <= '0;
                    vote_cnt           <= '0;
                    bit_cnt            <= bit_cnt + BW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Self-checking bench for puf_crp_sequencer: behavioural PUF stand-in, reference
// prediction of challenges and voted words, and a queue-based response monitor.
module tb_puf_crp_sequencer;

    localparam int SETTLE = 16;
    localparam int VOTES  = 5;
    localparam int BITS   = 8;
    localparam int LAT    = BITS * (VOTES * (2 * SETTLE + 1) + 1);

    localparam int MODE_ONE  = 0;
    localparam int MODE_CH0  = 1;
    localparam int MODE_MASK = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [7:0]      seed;
    logic [7:0]      CH;
    logic            PUF_In;
    logic            XOR_PUF_Out;
    logic [BITS-1:0] resp_word;
    logic            resp_valid;
    logic            resp_ready;
    logic            busy;

    always #5 clk = ~clk;

    puf_crp_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .VOTES         (VOTES),
        .RESP_BITS     (BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed        (seed),
        .CH          (CH),
        .PUF_In      (PUF_In),
        .XOR_PUF_Out (XOR_PUF_Out),
        .resp_word   (resp_word),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .busy        (busy)
    );

    typedef struct {
        logic [7:0] word;
        int         start_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          puf_mode;
    logic [39:0] puf_mask;
    logic [7:0]  exp_ch [0:BITS];
    logic [7:0]  last_word;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_lfsr(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    // Reference: challenge sequence and majority-voted word for the current PUF model.
    task automatic predict(input logic [7:0] s, output logic [7:0] w);
        logic [7:0] ch;
        int ones;
        ch = (s == 8'h00) ? 8'h01 : s;
        w  = '0;
        for (int i = 0; i < BITS; i++) begin
            exp_ch[i] = ch;
            ones = 0;
            for (int t = 0; t < VOTES; t++) begin
                if (puf_mode == MODE_ONE)      ones += 1;
                else if (puf_mode == MODE_CH0) ones += int'(ch[0]);
                else                           ones += int'(puf_mask[i*VOTES + t]);
            end
            w[i] = (ones > VOTES / 2);
            ch = ref_lfsr(ch);
        end
        exp_ch[BITS] = ch;
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input logic [7:0] s, input int mode, input logic [39:0] m);
        exp_t e;
        puf_mode = mode;
        puf_mask = m;
        predict(s, e.word);
        seed  = s;
        start = 1'b1;
        step();
        start = 1'b0;
        e.start_cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        check({name, "_done_in_budget"}, 32'(n < budget), 32'd1);
    endtask

    // PUF stand-in: counts excitation edges in a run and answers per the active model.
    initial begin
        int   k;
        int   hi;
        logic prev;
        k = 0;
        hi = 0;
        prev = 1'b0;
        XOR_PUF_Out = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !busy) k = 0;
            if (rst) begin
                hi   = 0;
                prev = 1'b0;
            end else begin
                if (PUF_In && !prev) begin
                    if (k < BITS * VOTES) begin
                        check("ch_per_trial", CH, exp_ch[k / VOTES]);
                        if (puf_mode == MODE_MASK) XOR_PUF_Out = puf_mask[k];
                    end
                    k++;
                end
                if (PUF_In) begin
                    hi++;
                end else if (prev) begin
                    check("pulse_width", hi, SETTLE + 1);
                    hi = 0;
                end
                prev = PUF_In;
            end
            if (puf_mode == MODE_CH0)      XOR_PUF_Out = CH[0];
            else if (puf_mode == MODE_ONE) XOR_PUF_Out = 1'b1;
        end
    end

    // Response monitor: latency on valid rise, word on handshake, release afterwards.
    initial begin
        exp_t e;
        logic pv;
        logic hs;
        pv = 1'b0;
        hs = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                hs = 1'b0;
            end else begin
                if (hs) begin
                    check("post_hs_valid", resp_valid, 0);
                    check("post_hs_busy", busy, 0);
                    hs = 1'b0;
                end
                if (resp_valid && !pv) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_valid: got valid with no run outstanding (cycle %0d)", cyc);
                    end else begin
                        check("latency", cyc - exp_q[0].start_cyc, LAT);
                    end
                end
                if (resp_valid && resp_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("resp_word", resp_word, e.word);
                    check("ch_held_done", CH, exp_ch[BITS]);
                    last_word = resp_word;
                    hs = 1'b1;
                end
                pv = resp_valid;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] m;
        int n;
        rst        = 1'b1;
        start      = 1'b1;
        seed       = 8'h5A;
        resp_ready = 1'b1;
        puf_mode   = MODE_ONE;
        puf_mask   = '0;
        last_word  = '0;

        step(3);
        check("rst_ch", CH, 0);
        check("rst_puf_in", PUF_In, 0);
        check("rst_word", resp_word, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("start_during_rst_ignored", busy, 0);

        launch(8'hA5, MODE_ONE, '0);
        wait_idle("const1", LAT + 50);
        check("const1_word", last_word, 8'hFF);

        launch(8'hA5, MODE_CH0, '0);
        wait_idle("ch0", LAT + 50);
        check("ch0_word", last_word, 8'hE5);

        launch(8'h00, MODE_CH0, '0);
        wait_idle("zero_seed", LAT + 50);

        // bit0 voted on trials 1,3 only; bit1 on trials 1,3,5
        m = 40'({$urandom(), $urandom()});
        m[9:0] = 10'b10101_00101;
        launch(8'(($urandom_range(255, 1))), MODE_MASK, m);
        wait_idle("majority", LAT + 50);
        check("majority_bits", 32'(last_word[1:0]), 32'b10);

        for (int r = 0; r < 4; r++) begin
            m = 40'({$urandom(), $urandom()});
            launch(8'($urandom_range(255, 0)), $urandom_range(MODE_MASK, MODE_ONE), m);
            wait_idle("random", LAT + 50);
        end

        resp_ready = 1'b0;
        m = 40'({$urandom(), $urandom()});
        launch(8'h3C, MODE_MASK, m);
        n = 0;
        while (!resp_valid && n < LAT + 50) begin
            step();
            n++;
        end
        check("bp_reach_done", 32'(n < LAT + 50), 32'd1);
        for (int i = 0; i < 50; i++) begin
            start = (i == 20);
            seed  = 8'hFF;
            step();
            check("bp_valid", resp_valid, 1);
            check("bp_word", resp_word, exp_q.size() != 0 ? exp_q[0].word : 8'h00);
            check("bp_ch", CH, exp_ch[BITS]);
        end
        start      = 1'b1;
        resp_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        check("hs_start_ignored", busy, 0);
        wait_idle("bp", 10);

        m = 40'({$urandom(), $urandom()});
        launch(8'h77, MODE_MASK, m);
        step(500);
        rst = 1'b1;
        exp_q.delete();
        step();
        check("midrst_puf_in", PUF_In, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", resp_valid, 0);
        check("midrst_ch", CH, 0);
        rst = 1'b0;
        step(20);
        check("midrst_stays_idle", busy, 0);
        launch(8'h77, MODE_MASK, m);
        wait_idle("after_rst", LAT + 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
